// File: rtl/move_sequencer_if.sv
// move_sequencer_if: host command channel (valid/ready with a 4-bit command code)
interface move_sequencer_if;
  logic cmd_valid;
  logic [3:0] cmd_code;
  logic cmd_ready;
  modport master(output cmd_valid, cmd_code, input cmd_ready);
  modport slave(input cmd_valid, cmd_code, output cmd_ready);
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer: queues host moves and issues them to motorMain one pulse at a time with timeout and settle gap
module move_sequencer #(
  parameter int DEPTH = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter logic [15:0] GAP_CYCLES = 16'd50_000,
  parameter logic HOME_ON_RESET = 1'b1
) (
  input logic clk,
  input logic reset_n,
  move_sequencer_if.slave cmd,
  input logic abort,
  input logic clear_error,
  input logic move_done,
  input logic reset_done,
  input logic offset_done,
  output logic [7:0] direction,
  output logic scan_offset_move,
  output logic scan_move,
  output logic horizontal_offset,
  output logic motor_reset,
  output logic busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic seq_done,
  output logic illegal_cmd,
  output logic error
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SETTLE, HALT} state_t;
  state_t state;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic started, aborted;
  logic [1:0] src;
  logic [23:0] tcnt;
  logic [15:0] gcnt;
  logic push, pop, flush, done_exp, time_hit, gap_hit, settle_end, issue_next;
  logic [3:0] head, wr_code;
  assign head = mem[rd_ptr];
  assign cmd.cmd_ready = started && !fifo_count[AW] && state != HALT;
  assign wr_code = started ? cmd.cmd_code : 4'd8;
  assign push = (!started && HOME_ON_RESET) || (cmd.cmd_valid && cmd.cmd_ready && cmd.cmd_code <= 4'd11 && !abort);
  assign pop = state == ISSUE;
  assign done_exp = src == 2'd1 ? reset_done : src == 2'd2 ? offset_done : move_done;
  assign time_hit = {1'b0, tcnt} + 25'd1 >= {1'b0, TIMEOUT_CYCLES};
  assign gap_hit = !done_exp && ({1'b0, gcnt} + 17'd1 >= {1'b0, GAP_CYCLES});
  assign settle_end = state == SETTLE && gap_hit;
  assign flush = (abort && state != HALT) || (state == WAIT && !done_exp && time_hit);
  assign issue_next = !abort && fifo_count != '0 && (state == IDLE || (settle_end && !aborted));
  assign busy = state != IDLE || fifo_count != '0;
  // command storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_code;
  // FIFO pointers and occupancy; the first clock after reset release enables the host side
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_count <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  // sequencing FSM; pulses are registered on the edge that enters ISSUE so they last exactly the ISSUE cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      src <= '0;
      tcnt <= '0;
      gcnt <= '0;
      aborted <= 1'b0;
      error <= 1'b0;
      direction <= '0;
      motor_reset <= 1'b0;
      scan_offset_move <= 1'b0;
      scan_move <= 1'b0;
      horizontal_offset <= 1'b0;
      seq_done <= 1'b0;
      illegal_cmd <= 1'b0;
    end else begin
      direction <= issue_next && !head[3] ? 8'd1 << head[2:0] : 8'd0;
      motor_reset <= issue_next && head == 4'd8;
      scan_offset_move <= issue_next && head == 4'd9;
      scan_move <= issue_next && head == 4'd10;
      horizontal_offset <= issue_next && head == 4'd11;
      illegal_cmd <= cmd.cmd_valid && cmd.cmd_ready && cmd.cmd_code > 4'd11;
      seq_done <= settle_end && !aborted && !abort && fifo_count == '0;
      aborted <= settle_end || issue_next ? 1'b0 : aborted || (abort && state inside {ISSUE, WAIT, SETTLE});
      if (issue_next) begin
        state <= ISSUE;
        tcnt <= '0;
        src <= head == 4'd8 ? 2'd1 : head == 4'd11 ? 2'd2 : 2'd0;
      end else
        case (state)
          ISSUE: state <= WAIT;
          WAIT:
            if (done_exp) begin
              state <= SETTLE;
              gcnt <= '0;
            end else if (time_hit) begin
              state <= HALT;
              error <= 1'b1;
            end else tcnt <= tcnt + 24'd1;
          SETTLE:
            if (gap_hit) state <= IDLE;
            else if (!done_exp && gcnt != '1) gcnt <= gcnt + 16'd1;
          HALT:
            if (clear_error) begin
              state <= IDLE;
              error <= 1'b0;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: randomized scoreboard plus directed boundary scenarios for move_sequencer
module tb_move_sequencer;
  localparam int DEPTH = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  logic abort = 1'b0, clear_error = 1'b0, move_done = 1'b0, reset_done = 1'b0, offset_done = 1'b0;
  logic [7:0] direction;
  logic scan_offset_move, scan_move, horizontal_offset, motor_reset, busy, seq_done, illegal_cmd, error;
  logic [$clog2(DEPTH):0] fifo_count;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int q[$];
  int script[$];
  bit in_flight = 0, exp_next = 0, pend_push = 0, pend_ill = 0, resp_on = 1, exp_lvl = 0;
  int pend_code = 0, settle_at = -1, r_src = 0, r_wait = 0, r_hold = 0, rand_pct = 0;

  move_sequencer_if cmd();

  move_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(24'd100), .GAP_CYCLES(16'd4), .HOME_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd), .abort(abort), .clear_error(clear_error),
    .move_done(move_done), .reset_done(reset_done), .offset_done(offset_done),
    .direction(direction), .scan_offset_move(scan_offset_move), .scan_move(scan_move),
    .horizontal_offset(horizontal_offset), .motor_reset(motor_reset), .busy(busy),
    .fifo_count(fifo_count), .seq_done(seq_done), .illegal_cmd(illegal_cmd), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // all motorMain pulses as one vector, bit index = command code
  function automatic logic [11:0] pulses();
    return {horizontal_offset, scan_move, scan_offset_move, motor_reset, direction};
  endfunction

  // one cycle of the scoreboard: check at the negedge, then drive the next inputs
  task automatic step();
    int pre, mcount, c;
    logic [11:0] p;
    logic [2:0] noise;
    @(negedge clk);
    cyc++;
    p = pulses();
    pre = q.size();
    if (pend_push) q.push_back(pend_code);
    mcount = q.size();
    check("illegal", illegal_cmd, pend_ill);
    check("count", fifo_count, mcount);
    check("ready", cmd.cmd_ready, mcount < DEPTH);
    if (cyc == settle_at) begin
      check("gap_issue", p != 0, pre != 0);
      check("seq_done", seq_done, pre == 0);
      in_flight = pre != 0;
    end else begin
      check("issue", p != 0, exp_next);
      check("seq_quiet", seq_done, 0);
    end
    if (p != 0) begin
      check("pulse", p, q.size() != 0 ? 12'(1) << q[0] : 12'(0));
      if (q.size() != 0) begin
        r_src = q[0] == 8 ? 1 : q[0] == 11 ? 2 : 0;
        void'(q.pop_front());
      end
      in_flight = 1;
      r_wait = $urandom_range(9, 2);
      r_hold = $urandom_range(3, 1);
    end
    exp_next = !in_flight && q.size() != 0;
    if (resp_on) begin
      if (r_wait > 0) begin
        r_wait--;
        if (r_wait == 0) exp_lvl = 1;
      end else if (r_hold > 0) begin
        r_hold--;
        if (r_hold == 0) begin
          exp_lvl = 0;
          settle_at = cyc + 4;
        end
      end
      noise = (r_wait > 0 || r_hold > 0) ? 3'($urandom) : 3'b000;
      move_done = r_src == 0 ? exp_lvl : noise[0];
      reset_done = r_src == 1 ? exp_lvl : noise[1];
      offset_done = r_src == 2 ? exp_lvl : noise[2];
    end
    pend_push = 0;
    pend_ill = 0;
    cmd.cmd_valid = 1'b0;
    if (script.size() != 0 || $urandom_range(99, 0) < rand_pct) begin
      c = script.size() != 0 ? script.pop_front() : ($urandom_range(9, 0) == 0 ? $urandom_range(15, 12) : $urandom_range(11, 0));
      cmd.cmd_valid = 1'b1;
      cmd.cmd_code = 4'(c);
      pend_code = c;
      pend_push = mcount < DEPTH && c <= 11;
      pend_ill = mcount < DEPTH && c >= 12;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((script.size() != 0 || q.size() != 0 || in_flight || pend_push) && n < 3000);
    check("drain_bound", n < 3000, 1);
  endtask

  initial begin
    cmd.cmd_valid = 1'b0;
    cmd.cmd_code = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_pulses", pulses(), 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", cmd.cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {seq_done, illegal_cmd, error}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("home_queued", fifo_count, 1);
    check("ready_after_release", cmd.cmd_ready, 1);
    check("home_not_yet", pulses(), 0);
    @(negedge clk);
    check("home_pulse", pulses(), 12'h100);
    @(negedge clk);
    check("home_pulse_width", pulses(), 0);
    check("home_busy", busy, 1);
    repeat (19) @(negedge clk);
    reset_done = 1'b1;
    repeat (2) @(negedge clk);
    reset_done = 1'b0;
    repeat (3) @(negedge clk);
    check("home_gap_early", seq_done, 0);
    @(negedge clk);
    check("home_seq_done", seq_done, 1);
    check("home_idle", busy, 0);
    @(negedge clk);
    check("home_seq_width", seq_done, 0);
    cyc = 0;
    script = '{6, 1, 10};
    rand_pct = 0;
    drain();
    rand_pct = 40;
    repeat (800) step();
    rand_pct = 0;
    drain();
    resp_on = 0;
    move_done = 1'b0;
    reset_done = 1'b0;
    offset_done = 1'b0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_code = 4'd2;
    @(negedge clk);
    cmd.cmd_code = 4'd3;
    repeat (24) @(negedge clk);
    check("full_count", fifo_count, 16);
    check("full_ready", cmd.cmd_ready, 0);
    repeat (2) @(negedge clk);
    check("full_reject", fifo_count, 16);
    cmd.cmd_valid = 1'b0;
    move_done = 1'b1;
    @(negedge clk);
    move_done = 1'b0;
    repeat (4) @(negedge clk);
    check("full_next_pulse", pulses(), 12'h008);
    check("full_count_issue", fifo_count, 16);
    reset_done = 1'b1;
    offset_done = 1'b1;
    @(negedge clk);
    check("slot_freed", fifo_count, 15);
    check("slot_ready", cmd.cmd_ready, 1);
    repeat (99) @(negedge clk);
    check("timeout_early", error, 0);
    check("timeout_count_early", fifo_count, 15);
    @(negedge clk);
    check("timeout_error", error, 1);
    check("timeout_flush", fifo_count, 0);
    check("halt_ready", cmd.cmd_ready, 0);
    reset_done = 1'b0;
    offset_done = 1'b0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_code = 4'd0;
    abort = 1'b1;
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
    abort = 1'b0;
    check("halt_no_push", fifo_count, 0);
    check("halt_sticky", error, 1);
    check("halt_no_pulse", pulses(), 0);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    check("clear_error", error, 0);
    check("clear_ready", cmd.cmd_ready, 1);
    check("clear_idle", busy, 0);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_code = 4'd13;
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
    check("illegal_pulse", illegal_cmd, 1);
    check("illegal_count", fifo_count, 0);
    @(negedge clk);
    check("illegal_width", illegal_cmd, 0);
    check("illegal_no_pulse", pulses(), 0);
    check("illegal_stays_empty", fifo_count, 0);
    foreach (script[i]) script.delete(i);
    cmd.cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd.cmd_code = 4'(i < 3 ? i : i + 1);
      @(negedge clk);
    end
    cmd.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_queued", fifo_count, 5);
    abort = 1'b1;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_code = 4'd4;
    @(negedge clk);
    abort = 1'b0;
    cmd.cmd_valid = 1'b0;
    check("abort_flush", fifo_count, 0);
    move_done = 1'b1;
    @(negedge clk);
    move_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_pulse", pulses(), 0);
      check("abort_no_seq_done", seq_done, 0);
    end
    check("abort_idle", busy, 0);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_code = 4'd9;
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
    @(negedge clk);
    check("scan_offset_pulse", pulses(), 12'h200);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_pulses", pulses(), 0);
    check("midreset_count", fifo_count, 0);
    check("midreset_busy", busy, 0);
    check("midreset_ready", cmd.cmd_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rehome_queued", fifo_count, 1);
    check("rehome_ready", cmd.cmd_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
